// File: rtl/parking_exit_controller.sv
// Exit-side parking controller: tracks per-slot entry times, quotes a time-based
// fee on exit, waits for payment, opens the gate, then releases the slot.
module parking_exit_controller #(
  parameter int NUM_SLOTS   = 4,
  parameter int TIME_W      = 8,
  parameter int FEE_W       = 16,
  parameter int RATE        = 5,
  parameter int GATE_CYCLES = 3,
  parameter int PAY_TIMEOUT = 64,
  localparam int SW = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 tick,
  input  logic                 assign_valid,
  input  logic [SW-1:0]        assign_slot,
  input  logic                 exit_req,
  input  logic [SW-1:0]        exit_slot,
  input  logic                 pay_ok,
  input  logic                 pay_cancel,
  output logic [FEE_W-1:0]     fee_out,
  output logic                 fee_valid,
  output logic                 gate_open,
  output logic                 release_valid,
  output logic [SW-1:0]        release_slot,
  output logic                 exit_err,
  output logic                 busy,
  output logic [NUM_SLOTS-1:0] occupied
);

  localparam int NP = 1 << SW;
  localparam int CW = $clog2(PAY_TIMEOUT + GATE_CYCLES + 1);
  localparam int PW = TIME_W + FEE_W + 32;
  localparam logic [PW-1:0] FEE_MAX = (PW'(1) << FEE_W) - PW'(1);

  typedef enum logic [2:0] {S_IDLE, S_LOOKUP, S_QUOTE, S_GATE, S_RELEASE} state_t;

  state_t                          r_state;
  logic [TIME_W-1:0]               r_now;
  logic [NUM_SLOTS-1:0][TIME_W-1:0] r_entry;
  logic [NUM_SLOTS-1:0]            r_occ;
  logic [SW-1:0]                   r_slot;
  logic [CW-1:0]                   r_cnt;
  logic [FEE_W-1:0]                r_fee;
  logic                            r_err;

  logic [NP-1:0]     w_occ_pad;
  logic              w_assign_ok;
  logic              w_exit_ok;
  logic [TIME_W-1:0] w_entry;
  logic [TIME_W-1:0] w_dur;
  logic [TIME_W-1:0] w_units;
  logic [PW-1:0]     w_prod;
  logic [FEE_W-1:0]  w_fee;

  // Padding to a power of two makes out-of-range slots read as free.
  assign w_occ_pad   = NP'(r_occ);
  assign w_assign_ok = assign_valid && (32'(assign_slot) < NUM_SLOTS) && !w_occ_pad[assign_slot];
  assign w_exit_ok   = w_occ_pad[exit_slot];

  always_comb begin
    w_entry = '0;
    for (int i = 0; i < NUM_SLOTS; i++)
      if (r_slot == SW'(i)) w_entry = r_entry[i];
  end

  // Elapsed time wraps with the counter; a zero duration still bills one unit.
  assign w_dur   = r_now - w_entry;
  assign w_units = (w_dur == '0) ? TIME_W'(1) : w_dur;
  assign w_prod  = PW'(w_units) * PW'(RATE);
  assign w_fee   = (w_prod > FEE_MAX) ? FEE_MAX[FEE_W-1:0] : w_prod[FEE_W-1:0];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_now   <= '0;
      r_entry <= '0;
      r_occ   <= '0;
    end else begin
      if (tick) r_now <= r_now + TIME_W'(1);
      for (int i = 0; i < NUM_SLOTS; i++) begin
        if (w_assign_ok && assign_slot == SW'(i)) begin
          r_entry[i] <= r_now;
          r_occ[i]   <= 1'b1;
        end
        if (r_state == S_RELEASE && r_slot == SW'(i)) r_occ[i] <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_slot  <= '0;
      r_cnt   <= '0;
      r_fee   <= '0;
      r_err   <= 1'b0;
    end else begin
      r_err <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (exit_req) begin
            if (w_exit_ok) begin
              r_slot  <= exit_slot;
              r_state <= S_LOOKUP;
            end else begin
              r_err <= 1'b1;
            end
          end
        end
        S_LOOKUP: begin
          r_fee   <= w_fee;
          r_cnt   <= '0;
          r_state <= S_QUOTE;
        end
        S_QUOTE: begin
          if (pay_ok) begin
            r_cnt   <= '0;
            r_state <= S_GATE;
          end else if (pay_cancel || r_cnt == CW'(PAY_TIMEOUT - 1)) begin
            r_state <= S_IDLE;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        S_GATE: begin
          if (r_cnt == CW'(GATE_CYCLES - 1)) r_state <= S_RELEASE;
          else                               r_cnt   <= r_cnt + CW'(1);
        end
        S_RELEASE: r_state <= S_IDLE;
        default:   r_state <= S_IDLE;
      endcase
    end
  end

  assign fee_out       = r_fee;
  assign fee_valid     = (r_state == S_QUOTE);
  assign gate_open     = (r_state == S_GATE);
  assign release_valid = (r_state == S_RELEASE);
  assign release_slot  = r_slot;
  assign exit_err      = r_err;
  assign busy          = (r_state != S_IDLE);
  assign occupied      = r_occ;

endmodule

// File: tb/tb_parking_exit_controller.sv
// Randomized bench for parking_exit_controller with a transaction-level fee/occupancy model.
module tb_parking_exit_controller;
  logic clk = 1'b0, reset = 1'b1, tick = 1'b0;
  logic assign_valid = 1'b0, exit_req = 1'b0, pay_ok = 1'b0, pay_cancel = 1'b0;
  logic [1:0] assign_slot = '0, exit_slot = '0;

  logic [15:0] fee_out;   logic fee_valid, gate_open, release_valid, exit_err, busy;
  logic [1:0]  release_slot; logic [3:0] occupied;
  logic [15:0] b_fee_out; logic b_fee_valid, b_gate_open, b_release_valid, b_exit_err, b_busy;
  logic [1:0]  b_release_slot; logic [2:0] b_occupied;

  always #5 clk = ~clk;

  parking_exit_controller dut (
    .clk(clk), .reset(reset), .tick(tick), .assign_valid(assign_valid), .assign_slot(assign_slot),
    .exit_req(exit_req), .exit_slot(exit_slot), .pay_ok(pay_ok), .pay_cancel(pay_cancel),
    .fee_out(fee_out), .fee_valid(fee_valid), .gate_open(gate_open), .release_valid(release_valid),
    .release_slot(release_slot), .exit_err(exit_err), .busy(busy), .occupied(occupied));

  // Narrow time base and a non-power-of-two slot count for wrap and range cases.
  parking_exit_controller #(.NUM_SLOTS(3), .TIME_W(4)) dut_b (
    .clk(clk), .reset(reset), .tick(tick), .assign_valid(assign_valid), .assign_slot(assign_slot),
    .exit_req(exit_req), .exit_slot(exit_slot), .pay_ok(pay_ok), .pay_cancel(pay_cancel),
    .fee_out(b_fee_out), .fee_valid(b_fee_valid), .gate_open(b_gate_open),
    .release_valid(b_release_valid), .release_slot(b_release_slot), .exit_err(b_exit_err),
    .busy(b_busy), .occupied(b_occupied));

  int errs = 0, checks = 0;
  int now = 0;
  bit occ[4];
  int entry[4];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic cyc;
    @(posedge clk); #1;
  endtask

  function automatic logic [3:0] occ_vec();
    logic [3:0] v;
    for (int i = 0; i < 4; i++) v[i] = occ[i];
    return v;
  endfunction

  function automatic int fee_of(input int s);
    int units;
    units = (now - entry[s]) % 256;
    if (units == 0) units = 1;
    return (units * 5 > 65535) ? 65535 : units * 5;
  endfunction

  task automatic model_reset;
    now = 0;
    for (int i = 0; i < 4; i++) begin occ[i] = 0; entry[i] = 0; end
  endtask

  task automatic do_reset;
    reset = 1'b1; cyc; cyc; reset = 1'b0;
    model_reset;
  endtask

  task automatic do_ticks(input int n);
    if (n > 0) begin
      tick = 1'b1; repeat (n) cyc; tick = 1'b0;
      now += n;
    end
  endtask

  task automatic do_assign(input int s);
    assign_valid = 1'b1; assign_slot = 2'(s); cyc; assign_valid = 1'b0;
    if (!occ[s]) begin occ[s] = 1; entry[s] = now; end
    chk("occ_after_assign", occupied, occ_vec());
  endtask

  // action: 0 pay, 1 cancel, 2 pay+cancel together, 3 timeout, 4 assign during quote then pay
  task automatic exit_flow(input int s, input int action);
    exit_req = 1'b1; exit_slot = 2'(s); cyc; exit_req = 1'b0;
    if (!occ[s]) begin
      chk("err_pulse", exit_err, 1); chk("err_busy", busy, 0);
      cyc;
      chk("err_clear", exit_err, 0); chk("err_gate", gate_open, 0); chk("err_busy2", busy, 0);
      return;
    end
    chk("lookup_busy", busy, 1); chk("lookup_fv", fee_valid, 0);
    cyc;
    chk("quote_fv", fee_valid, 1); chk("quote_fee", fee_out, fee_of(s));
    if (action == 1) begin
      pay_cancel = 1'b1; cyc; pay_cancel = 1'b0;
      chk("cancel_busy", busy, 0); chk("cancel_gate", gate_open, 0);
      chk("cancel_occ", occupied, occ_vec());
      chk("cancel_fee_hold", fee_out, fee_of(s));
    end else if (action == 3) begin
      repeat (63) cyc;
      chk("to_still_quote", fee_valid, 1); chk("to_gate", gate_open, 0);
      cyc;
      chk("to_idle", busy, 0); chk("to_gate2", gate_open, 0); chk("to_occ", occupied, occ_vec());
    end else begin
      if (action == 4) do_assign($urandom_range(0, 3));
      pay_ok = 1'b1; pay_cancel = (action == 2); cyc; pay_ok = 1'b0; pay_cancel = 1'b0;
      for (int i = 0; i < 3; i++) begin
        chk("gate_on", gate_open, 1); chk("gate_norel", release_valid, 0);
        cyc;
      end
      chk("rel_valid", release_valid, 1); chk("rel_slot", release_slot, s);
      chk("rel_gate_off", gate_open, 0); chk("rel_occ_still", occupied[s], 1);
      cyc;
      occ[s] = 0;
      chk("rel_pulse_end", release_valid, 0); chk("rel_occ", occupied, occ_vec());
      chk("rel_idle", busy, 0);
    end
  endtask

  initial begin
    int s, a;
    model_reset;
    cyc; cyc; reset = 1'b0;
    chk("rst_busy", busy, 0); chk("rst_fee", fee_out, 0); chk("rst_fv", fee_valid, 0);
    chk("rst_gate", gate_open, 0); chk("rst_rel", release_valid, 0); chk("rst_relslot", release_slot, 0);
    chk("rst_err", exit_err, 0); chk("rst_occ", occupied, 0);

    // Narrow-counter wrap and out-of-range slot on the second instance
    do_ticks(14);
    exit_req = 1'b1; exit_slot = 2'd3; cyc; exit_req = 1'b0;
    chk("b_oor_err", b_exit_err, 1); chk("b_oor_busy", b_busy, 0);
    cyc;
    assign_valid = 1'b1; assign_slot = 2'd3; cyc; assign_valid = 1'b0;
    chk("b_oor_assign", b_occupied, 0);
    assign_valid = 1'b1; assign_slot = 2'd0; cyc; assign_valid = 1'b0;
    chk("b_assign0", b_occupied, 3'b001);
    do_ticks(3);
    exit_req = 1'b1; exit_slot = 2'd0; cyc; exit_req = 1'b0; cyc;
    chk("b_wrap_fv", b_fee_valid, 1); chk("b_wrap_fee", b_fee_out, 15);
    pay_cancel = 1'b1; cyc; pay_cancel = 1'b0;
    do_reset;
    chk("rst2_occ", occupied, 0); chk("rst2_b_occ", b_occupied, 0);

    do_assign(1); do_ticks(7); exit_flow(1, 0);
    do_assign(0); exit_flow(0, 1);
    exit_flow(2, 0);
    exit_flow(0, 3);
    exit_flow(0, 2);

    for (int it = 0; it < 60; it++) begin
      case ($urandom_range(0, 3))
        0: do_ticks($urandom_range(0, 40));
        1: do_assign($urandom_range(0, 3));
        default: begin
          s = $urandom_range(0, 3);
          a = $urandom_range(0, 9);
          exit_flow(s, (a < 4) ? 0 : (a < 6) ? 1 : (a < 7) ? 2 : (a < 8) ? 4 : (a < 9) ? 3 : 0);
        end
      endcase
    end

    // Reset during the second gate cycle aborts without a release pulse
    do_assign(2);
    exit_req = 1'b1; exit_slot = 2'd2; cyc; exit_req = 1'b0; cyc;
    pay_ok = 1'b1; cyc; pay_ok = 1'b0;
    cyc;
    chk("pre_rst_gate", gate_open, 1);
    reset = 1'b1; #1;
    chk("mid_rst_gate", gate_open, 0); chk("mid_rst_occ", occupied, 0); chk("mid_rst_busy", busy, 0);
    cyc; reset = 1'b0; model_reset;
    for (int i = 0; i < 6; i++) begin
      cyc;
      chk("post_rst_norel", release_valid, 0);
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
